uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Shares one 8N1 UART transmitter between two requesters (A, B)
//            with round-robin arbitration. Each frame latches one byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter logic [9:0] CLKS_PER_BIT = 10'd694
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ReqA,
   input  logic [7:0] DataA,
   output logic       AckA,
   input  logic       ReqB,
   input  logic [7:0] DataB,
   output logic       AckB,
   output logic       Tx,
   output logic       Busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam logic [9:0] c_reload = CLKS_PER_BIT - 10'd1;

   state_t      r_state;
   logic [9:0]  r_cnt;
   logic [2:0]  r_idx;
   logic [7:0]  r_data;
   logic        r_last_b;
   logic        r_tx;
   logic        r_busy;
   logic        r_acka;
   logic        r_ackb;

   logic        w_grant_a;
   logic        w_grant_b;
   logic        w_bit_end;

   // Round-robin: on a tie the requester that was not served last wins.
   assign w_grant_a = ReqA & (~ReqB | r_last_b);
   assign w_grant_b = ReqB & (~ReqA | ~r_last_b);
   assign w_bit_end = (r_cnt == 10'd0);

   // Arbitration, bit timing and serialisation; all outputs registered.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= c_reload;
         r_idx    <= 3'd0;
         r_data   <= 8'd0;
         r_last_b <= 1'b1;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
         r_acka   <= 1'b0;
         r_ackb   <= 1'b0;
      end else begin
         // Acks are single-cycle: any grant re-asserts them below.
         r_acka <= 1'b0;
         r_ackb <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= c_reload;
               r_idx <= 3'd0;
               r_tx  <= 1'b1;
               if (w_grant_a) begin
                  r_data   <= DataA;
                  r_acka   <= 1'b1;
                  r_last_b <= 1'b0;
                  r_tx     <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_START;
               end else if (w_grant_b) begin
                  r_data   <= DataB;
                  r_ackb   <= 1'b1;
                  r_last_b <= 1'b1;
                  r_tx     <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_cnt   <= c_reload;
                  r_tx    <= r_data[0];
                  r_state <= S_DATA;
               end else begin
                  r_cnt <= r_cnt - 10'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= c_reload;
                  if (r_idx == 3'd7) begin
                     r_idx   <= 3'd0;
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                     r_tx  <= r_data[r_idx + 3'd1];
                  end
               end else begin
                  r_cnt <= r_cnt - 10'd1;
               end
            end
            S_STOP: begin
               // After STOP the block always spends one cycle in IDLE.
               if (w_bit_end) begin
                  r_cnt   <= c_reload;
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 10'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign Tx   = r_tx;
   assign Busy = r_busy;
   assign AckA = r_acka;
   assign AckB = r_ackb;

endmodule
`default_nettype wire
